// File: rtl/e_mdu_if.sv
// e_mdu_if: operation, operand and result bundle between the E stage and the multiply/divide unit.
interface e_mdu_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       MDUOp;
  logic             start;
  logic             req;
  logic [WIDTH-1:0] MDU_A;
  logic [WIDTH-1:0] MDU_B;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] out;

  modport master (
    output MDUOp, start, req, MDU_A, MDU_B,
    input  busy, HI, LO, out
  );

  modport slave (
    input  MDUOp, start, req, MDU_A, MDU_B,
    output busy, HI, LO, out
  );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Define MDU_MADD_EN to add madd/maddu/msub accumulate operations.
// state  | meaning
// S_IDLE | nothing in flight; starts and mthi/mtlo accepted
// S_BUSY | counting down; HI/LO committed on the edge where counter is 1
module e_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MFHI  = 4'b0111;
  localparam logic [3:0] OP_MFLO  = 4'b1000;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b1001;
  localparam logic [3:0] OP_MADDU = 4'b1010;
  localparam logic [3:0] OP_MSUB  = 4'b1011;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, r_res_hi, r_res_lo;
  logic             r_res_we;

  logic             w_accept, w_commit, w_is_mul, w_is_div, w_res_we;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_mq, w_mr, w_sq, w_sr, w_uq, w_ur;

  assign w_prod_s = {{WIDTH{bus.MDU_A[WIDTH-1]}}, bus.MDU_A} * {{WIDTH{bus.MDU_B[WIDTH-1]}}, bus.MDU_B};
  assign w_prod_u = {{WIDTH{1'b0}}, bus.MDU_A} * {{WIDTH{1'b0}}, bus.MDU_B};

  // Signed divide via magnitudes: MIN/-1 wraps back to MIN with no special case.
  assign w_neg_a = bus.MDU_A[WIDTH-1];
  assign w_neg_b = bus.MDU_B[WIDTH-1];
  assign w_abs_a = w_neg_a ? -bus.MDU_A : bus.MDU_A;
  assign w_abs_b = w_neg_b ? -bus.MDU_B : bus.MDU_B;
  assign w_mq    = (w_abs_b != '0) ? w_abs_a / w_abs_b : '0;
  assign w_mr    = (w_abs_b != '0) ? w_abs_a % w_abs_b : '0;
  assign w_sq    = (w_neg_a ^ w_neg_b) ? -w_mq : w_mq;
  assign w_sr    = w_neg_a ? -w_mr : w_mr;
  assign w_uq    = (bus.MDU_B != '0) ? bus.MDU_A / bus.MDU_B : '0;
  assign w_ur    = (bus.MDU_B != '0) ? bus.MDU_A % bus.MDU_B : '0;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_res_we = 1'b1;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (bus.MDUOp)
      OP_MULT:  begin w_is_mul = 1'b1; {w_res_hi, w_res_lo} = w_prod_s; end
      OP_MULTU: begin w_is_mul = 1'b1; {w_res_hi, w_res_lo} = w_prod_u; end
      OP_DIV:   begin w_is_div = 1'b1; w_res_we = (bus.MDU_B != '0); w_res_lo = w_sq; w_res_hi = w_sr; end
      OP_DIVU:  begin w_is_div = 1'b1; w_res_we = (bus.MDU_B != '0); w_res_lo = w_uq; w_res_hi = w_ur; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin w_is_mul = 1'b1; {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_s; end
      OP_MADDU: begin w_is_mul = 1'b1; {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_u; end
      OP_MSUB:  begin w_is_mul = 1'b1; {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod_s; end
`endif
      default: ;
    endcase
  end

  assign w_accept = bus.start && !bus.req && (r_state == S_IDLE) && (w_is_mul || w_is_div);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_BUSY;
        w_cnt_nxt   = w_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end
      S_BUSY: if (r_cnt == CW'(1)) begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_res_we <= 1'b0;
    end else begin
      if (w_accept) begin
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
        r_res_we <= w_res_we;
      end
      if (w_commit) begin
        if (r_res_we) begin
          r_hi <= r_res_hi;
          r_lo <= r_res_lo;
        end
      end else if (r_state == S_IDLE && !bus.req) begin
        if (bus.MDUOp == OP_MTHI) r_hi <= bus.MDU_A;
        if (bus.MDUOp == OP_MTLO) r_lo <= bus.MDU_A;
      end
    end
  end

  assign bus.busy = (r_state == S_BUSY);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.out  = (bus.MDUOp == OP_MFHI) ? r_hi :
                    (bus.MDUOp == OP_MFLO) ? r_lo : '0;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and random stimulus for e_mdu, checked every cycle against an arithmetic model.
module tb_e_mdu;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  e_mdu_if #(.WIDTH(32)) bus();

  e_mdu #(.WIDTH(32), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_start_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd11);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  // Reference model: HI/LO, cycles of busy remaining, and the result due at completion.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_we = 1'b0;
  int          m_left = 0;
  bit          m_valid = 1'b0;
  logic [31:0] ma, mb;
  logic [3:0]  mop;
  longint      sp;
  logic [63:0] up, acc, res;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else begin
      mop = bus.MDUOp; ma = bus.MDU_A; mb = bus.MDU_B;
      if (bus.start && !bus.req && is_start_op(mop)) begin
        sp  = longint'(int'(ma)) * longint'(int'(mb));
        up  = {32'h0, ma} * {32'h0, mb};
        acc = {m_hi, m_lo};
        res = acc;
        m_we = 1'b1;
        m_left = MULC;
        case (mop)
          4'd1:  res = sp;
          4'd2:  res = up;
          4'd3: begin
            m_left = DIVC;
            if (mb == 32'h0) m_we = 1'b0;
            else if (ma == 32'h80000000 && mb == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
            else res = {32'(int'(ma) % int'(mb)), 32'(int'(ma) / int'(mb))};
          end
          4'd4: begin
            m_left = DIVC;
            if (mb == 32'h0) m_we = 1'b0;
            else res = {ma % mb, ma / mb};
          end
          4'd9:  res = acc + sp;
          4'd10: res = acc + up;
          4'd11: res = acc - sp;
          default: ;
        endcase
        m_phi = res[63:32];
        m_plo = res[31:0];
      end else if (!bus.req) begin
        if (mop == 4'd5) m_hi = ma;
        if (mop == 4'd6) m_lo = ma;
      end
    end
  end

  logic [31:0] exp_out;
  always @(negedge clk) begin
    if (m_valid && !reset) begin
      exp_out = (bus.MDUOp == 4'd7) ? m_hi : (bus.MDUOp == 4'd8) ? m_lo : 32'h0;
      chk("busy", {31'h0, bus.busy}, {31'h0, (m_left > 0)});
      chk("HI", bus.HI, m_hi);
      chk("LO", bus.LO, m_lo);
      chk("out", bus.out, exp_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic st, input logic rq,
                       input logic [31:0] a, input logic [31:0] b);
    bus.MDUOp = op; bus.start = st; bus.req = rq; bus.MDU_A = a; bus.MDU_B = b;
    step();
    bus.MDUOp = 4'd0; bus.start = 1'b0; bus.req = 1'b0;
  endtask

  task automatic busy_len(input string name, input int exp_n);
    int n;
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      step();
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic st, rq;
    int g;
    bus.MDUOp = 4'd0; bus.start = 1'b0; bus.req = 1'b0;
    bus.MDU_A = '0; bus.MDU_B = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_HI", bus.HI, 32'h0);
    chk("reset_LO", bus.LO, 32'h0);

    drive(4'd1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'd3);
    busy_len("mult_cycles", MULC);
    chk("mult_HI", bus.HI, 32'hFFFFFFFF);
    chk("mult_LO", bus.LO, 32'hFFFFFFFA);
    chk("model_mult_LO", m_lo, 32'hFFFFFFFA);

    drive(4'd3, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
    busy_len("div_cycles", DIVC);
    chk("div_LO", bus.LO, 32'hFFFFFFFD);
    chk("div_HI", bus.HI, 32'hFFFFFFFF);
    chk("model_div_HI", m_hi, 32'hFFFFFFFF);

    drive(4'd4, 1'b1, 1'b0, 32'd7, 32'd0);
    busy_len("divu0_cycles", DIVC);
    chk("divu0_LO", bus.LO, 32'hFFFFFFFD);
    chk("divu0_HI", bus.HI, 32'hFFFFFFFF);

    drive(4'd2, 1'b1, 1'b1, 32'd5, 32'd6);
    chk("req_start_busy", {31'h0, bus.busy}, 32'h0);
    chk("req_start_LO", bus.LO, 32'hFFFFFFFD);
    drive(4'd6, 1'b0, 1'b1, 32'h55, 32'h0);
    chk("req_mtlo_LO", bus.LO, 32'hFFFFFFFD);

    drive(4'd5, 1'b0, 1'b0, 32'h1234, 32'h0);
    bus.MDUOp = 4'd7;
    #1;
    chk("mfhi_out", bus.out, 32'h1234);
    step();

    drive(4'd3, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    busy_len("divmin_cycles", DIVC);
    chk("divmin_LO", bus.LO, 32'h80000000);
    chk("divmin_HI", bus.HI, 32'h0);

    drive(4'd5, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(4'd6, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0);
    drive(4'd10, 1'b1, 1'b0, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    busy_len("maddu_cycles", MULC);
    chk("maddu_HI", bus.HI, 32'h1);
    chk("maddu_LO", bus.LO, 32'h0);
`else
    busy_len("maddu_cycles", 0);
    chk("maddu_HI", bus.HI, 32'h0);
    chk("maddu_LO", bus.LO, 32'hFFFFFFFF);
`endif

    drive(4'd5, 1'b0, 1'b0, 32'hAA, 32'h0);
    drive(4'd6, 1'b0, 1'b0, 32'hBB, 32'h0);
    drive(4'd3, 1'b1, 1'b0, 32'd100, 32'd7);
    repeat (6) step();
    chk("middiv_busy", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_HI", bus.HI, 32'h0);
    chk("abort_LO", bus.LO, 32'h0);
    bus.MDUOp = 4'd8;
    #1;
    chk("abort_mflo", bus.out, 32'h0);
    step();

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 11));
      st = is_start_op(op) || (op >= 4'd9 && op <= 4'd11) ? ($urandom_range(0, 9) != 0) : 1'b0;
      rq = ($urandom_range(0, 3) == 0);
      drive(op, st, rq, pick_val(), pick_val());
      g = 0;
      while (m_left > 0 && g < 64) begin
        g++;
        step();
      end
      if (g >= 64) chk("rand_drain", 32'(m_left), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
